led_band_loader: RTL and testbench



---
 rtl/led_band_loader.sv | 135 +++++++++++++
 tb/tb_led_band_loader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/led_band_loader.sv
// Packs a byte stream into W_DATA_WIDTH-bit words and issues one memory write per word.
// Byte k of each word lands in lane k; words are written to consecutive addresses from 0.
module led_band_loader #(
  parameter int W_ADDR_WIDTH = 11,
  parameter int W_DATA_WIDTH = 128,
  parameter int BYTE_WIDTH   = 8,
  parameter int FRAME_WORDS  = 864
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    frame_start,
  input  logic                    in_valid,
  input  logic [BYTE_WIDTH-1:0]   in_data,
  output logic                    in_ready,
  output logic                    write,
  output logic [W_ADDR_WIDTH-1:0] w_addr,
  output logic [W_DATA_WIDTH-1:0] w_data,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    aborted
);

  localparam int LANES  = W_DATA_WIDTH / BYTE_WIDTH;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0]       LAST_LANE = LANE_W'(LANES - 1);
  localparam logic [W_ADDR_WIDTH-1:0] LAST_WORD = W_ADDR_WIDTH'(FRAME_WORDS - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t                  state_reg, state_next;
  logic [LANE_W-1:0]       lane_reg, lane_next;
  logic [W_ADDR_WIDTH-1:0] word_idx_reg, word_idx_next;
  logic [W_DATA_WIDTH-1:0] acc_reg, acc_next;
  logic [W_DATA_WIDTH-1:0] w_data_reg, w_data_next;
  logic [W_ADDR_WIDTH-1:0] w_addr_reg, w_addr_next;
  logic                    write_reg, write_next;
  logic                    in_ready_reg, in_ready_next;
  logic                    frame_done_reg, frame_done_next;
  logic                    aborted_reg, aborted_next;
  logic                    accept;
  logic [W_DATA_WIDTH-1:0] merged;

  assign accept = in_valid && in_ready_reg;

  // Accumulator with the incoming byte substituted into the current lane.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign merged[gi*BYTE_WIDTH +: BYTE_WIDTH] =
        (lane_reg == LANE_W'(gi)) ? in_data : acc_reg[gi*BYTE_WIDTH +: BYTE_WIDTH];
    end
  endgenerate

  always_comb begin
    state_next      = state_reg;
    lane_next       = lane_reg;
    word_idx_next   = word_idx_reg;
    acc_next        = acc_reg;
    w_data_next     = w_data_reg;
    w_addr_next     = w_addr_reg;
    write_next      = 1'b0;
    frame_done_next = 1'b0;
    aborted_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (frame_start) begin
          state_next    = FILL;
          lane_next     = '0;
          word_idx_next = '0;
        end
      end
      FILL: begin
        if (frame_start) begin
          // Restart wins over any byte in the same cycle, even a word-completing one.
          lane_next     = '0;
          word_idx_next = '0;
          aborted_next  = 1'b1;
        end else if (accept) begin
          acc_next = merged;
          if (lane_reg == LAST_LANE) begin
            lane_next   = '0;
            write_next  = 1'b1;
            w_data_next = merged;
            w_addr_next = word_idx_reg;
            if (word_idx_reg == LAST_WORD) begin
              state_next      = IDLE;
              word_idx_next   = '0;
              frame_done_next = 1'b1;
            end else begin
              word_idx_next = word_idx_reg + 1'b1;
            end
          end else begin
            lane_next = lane_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    in_ready_next = (state_next == FILL);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_reg      <= IDLE;
      lane_reg       <= '0;
      word_idx_reg   <= '0;
      acc_reg        <= '0;
      w_data_reg     <= '0;
      w_addr_reg     <= '0;
      write_reg      <= 1'b0;
      in_ready_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
      aborted_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      lane_reg       <= lane_next;
      word_idx_reg   <= word_idx_next;
      acc_reg        <= acc_next;
      w_data_reg     <= w_data_next;
      w_addr_reg     <= w_addr_next;
      write_reg      <= write_next;
      in_ready_reg   <= in_ready_next;
      frame_done_reg <= frame_done_next;
      aborted_reg    <= aborted_next;
    end
  end

  assign in_ready   = in_ready_reg;
  assign busy       = in_ready_reg;
  assign write      = write_reg;
  assign w_addr     = w_addr_reg;
  assign w_data     = w_data_reg;
  assign frame_done = frame_done_reg;
  assign aborted    = aborted_reg;

endmodule

// File: tb/tb_led_band_loader.sv
// Directed bench for led_band_loader: full frames, gapped stream, restarts and mid-frame reset.
module tb_led_band_loader;
  localparam int FW = 864;

  logic         clk = 1'b0;
  logic         nrst;
  logic         frame_start;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_ready;
  logic         write;
  logic [10:0]  w_addr;
  logic [127:0] w_data;
  logic         busy;
  logic         frame_done;
  logic         aborted;

  int checks = 0;
  int failures = 0;

  logic [127:0] mem [FW];
  int           wcount [FW];
  int           wr_cnt = 0;

  led_band_loader dut (
    .clk(clk), .nrst(nrst), .frame_start(frame_start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .write(write), .w_addr(w_addr),
    .w_data(w_data), .busy(busy), .frame_done(frame_done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  // Memory model: captures every write in the middle of its cycle.
  always @(negedge clk) begin
    if (write === 1'b1) begin
      wr_cnt = wr_cnt + 1;
      if (int'(w_addr) < FW) begin
        mem[w_addr] = w_data;
        wcount[w_addr] = wcount[w_addr] + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Streams n consecutive bytes start, start+1, ...; checks every write against a lane model.
  task automatic send_bytes(input int n, input logic [7:0] start, input int woff);
    logic [127:0] cur;
    logic [7:0]   b;
    int           wi;
    cur = '0;
    for (int i = 0; i < n; i++) begin
      b = start + 8'(i);
      frame_start = 1'b0;
      in_valid = 1'b1;
      in_data = b;
      tick();
      cur[8*(i%16) +: 8] = b;
      if (i % 16 == 15) begin
        wi = woff + i / 16;
        chk("word_write", 128'(write), 128'(1));
        chk("word_addr", 128'(w_addr), 128'(wi));
        chk("word_data", w_data, cur);
        chk("word_done", 128'(frame_done), 128'(wi == FW - 1));
      end else begin
        chk("no_write", 128'(write), 128'(0));
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic clear_model();
    for (int a = 0; a < FW; a++) begin
      mem[a] = '0;
      wcount[a] = 0;
    end
  endtask

  initial begin
    int base;
    int accepted;
    int cyc;
    int bad;
    logic rdy;
    logic [7:0] exp_b;

    nrst = 1'b0; frame_start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    clear_model();
    tick(); tick();
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_write", 128'(write), 128'(0));
    chk("rst_w_addr", 128'(w_addr), 128'(0));
    chk("rst_w_data", w_data, 128'(0));
    chk("rst_done", 128'(frame_done), 128'(0));
    chk("rst_aborted", 128'(aborted), 128'(0));
    nrst = 1'b1;

    // IDLE ignores valid bytes
    in_valid = 1'b1; in_data = 8'h55;
    tick(); tick(); tick();
    chk("idle_ready", 128'(in_ready), 128'(0));
    chk("idle_no_write", 128'(wr_cnt), 128'(0));

    // Full frame; the byte in the frame_start cycle must be dropped
    frame_start = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
    tick();
    frame_start = 1'b0;
    chk("start_ready", 128'(in_ready), 128'(1));
    chk("start_busy", 128'(busy), 128'(1));
    send_bytes(13824, 8'h00, 0);
    chk("full_ready_low", 128'(in_ready), 128'(0));
    tick();
    chk("full_done_once", 128'(frame_done), 128'(0));
    chk("full_ready_after", 128'(in_ready), 128'(0));
    chk("full_word0", mem[0], 128'h0F0E0D0C0B0A09080706050403020100);
    chk("full_word863", mem[863], 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0);
    chk("full_wr_cnt", 128'(wr_cnt), 128'(FW));

    // Gapped stream with readback through the memory model
    clear_model();
    base = wr_cnt;
    frame_start = 1'b1; in_valid = 1'b0;
    tick();
    frame_start = 1'b0;
    accepted = 0; cyc = 0;
    while (accepted < 13824 && cyc < 60000) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data = 8'(accepted * 7 + 3);
      rdy = in_ready;
      tick();
      if (in_valid && rdy) accepted++;
      cyc++;
    end
    in_valid = 1'b0;
    chk("gap_accepted", 128'(accepted), 128'(13824));
    tick(); tick();
    chk("gap_wr_cnt", 128'(wr_cnt - base), 128'(FW));
    bad = 0;
    for (int b = 0; b < 13824; b++) begin
      exp_b = 8'(b * 7 + 3);
      if (mem[b / 16][8*(b % 16) +: 8] !== exp_b) bad++;
    end
    chk("gap_readback_bad", 128'(bad), 128'(0));
    bad = 0;
    for (int a = 0; a < FW; a++) if (wcount[a] != 1) bad++;
    chk("gap_one_write_per_word", 128'(bad), 128'(0));

    // Restart after 20 bytes
    base = wr_cnt;
    frame_start = 1'b1;
    tick();
    send_bytes(20, 8'h40, 0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("abort3_pulse", 128'(aborted), 128'(1));
    chk("abort3_no_write", 128'(write), 128'(0));
    chk("abort3_ready", 128'(in_ready), 128'(1));
    tick();
    chk("abort3_pulse_end", 128'(aborted), 128'(0));
    send_bytes(16, 8'h80, 0);
    tick();
    chk("abort3_wr_cnt", 128'(wr_cnt - base), 128'(2));

    // Restart coinciding with the 16th byte of word 5
    frame_start = 1'b1;
    tick();
    base = wr_cnt;
    send_bytes(95, 8'h10, 0);
    frame_start = 1'b1; in_valid = 1'b1; in_data = 8'h99;
    tick();
    frame_start = 1'b0; in_valid = 1'b0;
    chk("abort5_no_write", 128'(write), 128'(0));
    chk("abort5_pulse", 128'(aborted), 128'(1));
    chk("abort5_wr_cnt", 128'(wr_cnt - base), 128'(5));
    send_bytes(16, 8'hC0, 0);

    // Reset mid-word at word 100
    frame_start = 1'b1;
    tick();
    send_bytes(100 * 16 + 7, 8'h21, 0);
    base = wr_cnt;
    nrst = 1'b0; in_valid = 1'b1; in_data = 8'h77;
    tick();
    nrst = 1'b1;
    chk("mrst_in_ready", 128'(in_ready), 128'(0));
    chk("mrst_busy", 128'(busy), 128'(0));
    chk("mrst_write", 128'(write), 128'(0));
    chk("mrst_w_addr", 128'(w_addr), 128'(0));
    chk("mrst_w_data", w_data, 128'(0));
    chk("mrst_done", 128'(frame_done), 128'(0));
    chk("mrst_aborted", 128'(aborted), 128'(0));
    for (int i = 0; i < 16; i++) tick();
    chk("mrst_ignored_ready", 128'(in_ready), 128'(0));
    chk("mrst_ignored_writes", 128'(wr_cnt - base), 128'(0));
    in_valid = 1'b0;
    frame_start = 1'b1;
    tick();
    send_bytes(32, 8'hE0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
